// File: rtl/stage_id_pipe.sv
// stage_id_pipe: instruction-decode stage with an internal register file,
// load-use / writeback-collision hazard detection, immediate extension, an
// ID/EX pipeline register and a RUN/HALTED state machine.
// Optional feature macro: STAGE_ID_BYPASS_EN (same-cycle writeback bypass).
//
// Control bundle produced by control_unit (bit positions):
//   [1:0] extender mode  [2] halt       [3] reg_write  [4] mem_read
//   [5]   mem_write      [6] alu_src    [7] reg_dst    [8] branch
//   [15:10] funct (R-type only); bits above 15 read as 0.

module control_unit #(
    parameter int CTRL_W = 16
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] ctrl
);
    localparam logic [15:0] EXT_ZERO    = 16'h0000;
    localparam logic [15:0] EXT_SIGN    = 16'h0001;
    localparam logic [15:0] EXT_UPPER   = 16'h0002;
    localparam logic [15:0] EXT_ZERO_B  = 16'h0003;
    localparam logic [15:0] F_HALT      = 16'h0004;
    localparam logic [15:0] F_REG_WRITE = 16'h0008;
    localparam logic [15:0] F_MEM_READ  = 16'h0010;
    localparam logic [15:0] F_MEM_WRITE = 16'h0020;
    localparam logic [15:0] F_ALU_SRC   = 16'h0040;
    localparam logic [15:0] F_REG_DST   = 16'h0080;
    localparam logic [15:0] F_BRANCH    = 16'h0100;

    logic [15:0] bundle;

    // Decode the opcode (and funct for R-type) into the control bundle
    always_comb begin
        // NOTE: a default assignment first means every path drives the signal, so no latch is inferred.
        bundle = '0;
        case (opcode)
            6'h00:   bundle = {funct, 10'b0} | F_REG_WRITE | F_REG_DST;                // R-type
            6'h08:   bundle = EXT_SIGN   | F_REG_WRITE | F_ALU_SRC;                   // addi
            6'h0B:   bundle = EXT_ZERO_B | F_REG_WRITE | F_ALU_SRC;                   // sltiu
            6'h0C,
            6'h0D:   bundle = EXT_ZERO   | F_REG_WRITE | F_ALU_SRC;                   // andi, ori
            6'h0F:   bundle = EXT_UPPER  | F_REG_WRITE | F_ALU_SRC;                   // lui
            6'h23:   bundle = EXT_SIGN   | F_REG_WRITE | F_MEM_READ | F_ALU_SRC;      // lw
            6'h2B:   bundle = EXT_SIGN   | F_MEM_WRITE | F_ALU_SRC;                   // sw
            6'h04:   bundle = EXT_SIGN   | F_BRANCH;                                  // beq
            6'h3F:   bundle = F_HALT;                                                 // halt
            default: bundle = '0;
        endcase
    end

    assign ctrl = CTRL_W'(bundle);
endmodule

module stage_id_pipe #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ifid_valid,
    input  logic [31:0]       ifid_instr,
    input  logic [WORD_W-1:0] ifid_npc,
    output logic              ifid_ready,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_wsel,
    input  logic [WORD_W-1:0] wb_wdat,
    input  logic              wb_jal,
    input  logic [WORD_W-1:0] wb_npc,
    output logic              idex_valid,
    output logic [31:0]       idex_instr,
    output logic [WORD_W-1:0] idex_npc,
    output logic [WORD_W-1:0] idex_rdat1,
    output logic [WORD_W-1:0] idex_rdat2,
    output logic [WORD_W-1:0] idex_imm,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              halted,
    output logic [15:0]       stall_cnt
);
    localparam int NREGS = 2 ** REG_AW;

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

    state_e state_q, state_d;

    logic [REG_AW-1:0] rs, rt;
    logic [CTRL_W-1:0] ctrl_dec;
    logic [15:0]       imm16;
    logic [WORD_W-1:0] imm_ext;
    logic [WORD_W-1:0] rdat1, rdat2;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              load_use, collide, accept;

    logic [WORD_W-1:0] regs_q [NREGS];
    logic [WORD_W-1:0] regs_d [NREGS];

    logic              idex_valid_q, idex_valid_d;
    logic [31:0]       idex_instr_q, idex_instr_d;
    logic [WORD_W-1:0] idex_npc_q, idex_npc_d;
    logic [WORD_W-1:0] idex_rdat1_q, idex_rdat1_d;
    logic [WORD_W-1:0] idex_rdat2_q, idex_rdat2_d;
    logic [WORD_W-1:0] idex_imm_q, idex_imm_d;
    logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    assign rs    = ifid_instr[21 +: REG_AW];
    assign rt    = ifid_instr[16 +: REG_AW];
    assign imm16 = ifid_instr[15:0];

    control_unit #(.CTRL_W(CTRL_W)) u_ctrl (
        .opcode (ifid_instr[31:26]),
        .funct  (ifid_instr[5:0]),
        .ctrl   (ctrl_dec)
    );

    // Writeback port: register 0 is never written, jal writes the return address
    assign wr_en   = wb_wen & (wb_wsel != '0);
    assign wr_data = wb_jal ? wb_npc : wb_wdat;

    // Register file next-state: copy, then overlay the writeback word
    always_comb begin
        for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        if (wr_en) regs_d[wb_wsel] = wr_data;
    end

    // Register file storage, cleared by reset
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: the array is reset on purpose so r1..rN read 0 after reset; this forces flops rather than RAM.
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Operand read, optionally forwarding a coincident writeback
    always_comb begin
        rdat1 = regs_q[rs];
        rdat2 = regs_q[rt];
`ifdef STAGE_ID_BYPASS_EN
        if (wr_en && (wb_wsel == rs)) rdat1 = wr_data;
        if (wr_en && (wb_wsel == rt)) rdat2 = wr_data;
`endif
        if (rs == '0) rdat1 = '0;
        if (rt == '0) rdat2 = '0;
    end

`ifdef STAGE_ID_BYPASS_EN
    assign collide = 1'b0;
`else
    // Without bypass a coincident write costs one bubble; the stored value is read next cycle
    assign collide = ifid_valid & wr_en & ((wb_wsel == rs) | (wb_wsel == rt));
`endif

    assign load_use = ifid_valid & ex_memread & (ex_rd != '0) & ((ex_rd == rs) | (ex_rd == rt));
    assign accept   = ex_ready & ~load_use & ~collide;

    // Immediate extension selected by ctrl[1:0]
    always_comb begin
        case (ctrl_dec[1:0])
            2'd1:    imm_ext = {{(WORD_W-16){imm16[15]}}, imm16};
            2'd2:    imm_ext = {imm16, {(WORD_W-16){1'b0}}};
            default: imm_ext = {{(WORD_W-16){1'b0}}, imm16};
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!nRST) state_q <= RUN;
        else       state_q <= state_d;
    end

    // FSM next state: enter HALTED when a valid halt is actually loaded (flush wins)
    always_comb begin
        state_d = state_q;
        if ((state_q == RUN) && !flush && accept && ifid_valid && ctrl_dec[2]) state_d = HALTED;
    end

    // FSM outputs
    always_comb begin
        ifid_ready = 1'b0;
        halted     = 1'b0;
        case (state_q)
            RUN:     ifid_ready = flush | accept;
            HALTED:  halted = 1'b1;
            default: ifid_ready = 1'b0;
        endcase
    end

    // ID/EX next state: flush, then EX backpressure, then bubble, then load
    always_comb begin
        idex_valid_d = idex_valid_q;
        idex_instr_d = idex_instr_q;
        idex_npc_d   = idex_npc_q;
        idex_rdat1_d = idex_rdat1_q;
        idex_rdat2_d = idex_rdat2_q;
        idex_imm_d   = idex_imm_q;
        idex_ctrl_d  = idex_ctrl_q;
        if ((state_q == HALTED) || flush) begin
            idex_valid_d = 1'b0;
        end else if (ex_ready) begin
            if (load_use || collide) begin
                idex_valid_d = 1'b0;
            end else begin
                idex_valid_d = ifid_valid;
                idex_instr_d = ifid_instr;
                idex_npc_d   = ifid_npc;
                idex_rdat1_d = rdat1;
                idex_rdat2_d = rdat2;
                idex_imm_d   = imm_ext;
                idex_ctrl_d  = ctrl_dec;
            end
        end
    end

    // Saturating count of RUN cycles where a valid instruction was refused
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == RUN) && ifid_valid && !flush && !ifid_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // ID/EX register and stall counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idex_valid_q <= 1'b0;
            idex_instr_q <= '0;
            idex_npc_q   <= '0;
            idex_rdat1_q <= '0;
            idex_rdat2_q <= '0;
            idex_imm_q   <= '0;
            idex_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            idex_valid_q <= idex_valid_d;
            idex_instr_q <= idex_instr_d;
            idex_npc_q   <= idex_npc_d;
            idex_rdat1_q <= idex_rdat1_d;
            idex_rdat2_q <= idex_rdat2_d;
            idex_imm_q   <= idex_imm_d;
            idex_ctrl_q  <= idex_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign idex_valid = idex_valid_q;
    assign idex_instr = idex_instr_q;
    assign idex_npc   = idex_npc_q;
    assign idex_rdat1 = idex_rdat1_q;
    assign idex_rdat2 = idex_rdat2_q;
    assign idex_imm   = idex_imm_q;
    assign idex_ctrl  = idex_ctrl_q;
    assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed testbench for stage_id_pipe: expected ID/EX contents are queued when
// an instruction is presented and compared when the stage issues it.
// Honours STAGE_ID_BYPASS_EN for the writeback-collision expectations.

module tb_stage_id_pipe;
    localparam int WORD_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 16;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              ifid_valid;
    logic [31:0]       ifid_instr;
    logic [WORD_W-1:0] ifid_npc;
    logic              ifid_ready;
    logic              ex_ready;
    logic              flush;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_wsel;
    logic [WORD_W-1:0] wb_wdat;
    logic              wb_jal;
    logic [WORD_W-1:0] wb_npc;
    logic              idex_valid;
    logic [31:0]       idex_instr;
    logic [WORD_W-1:0] idex_npc;
    logic [WORD_W-1:0] idex_rdat1;
    logic [WORD_W-1:0] idex_rdat2;
    logic [WORD_W-1:0] idex_imm;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              halted;
    logic [15:0]       stall_cnt;

    stage_id_pipe #(.WORD_W(WORD_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_npc   (ifid_npc),
        .ifid_ready (ifid_ready),
        .ex_ready   (ex_ready),
        .flush      (flush),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .wb_wen     (wb_wen),
        .wb_wsel    (wb_wsel),
        .wb_wdat    (wb_wdat),
        .wb_jal     (wb_jal),
        .wb_npc     (wb_npc),
        .idex_valid (idex_valid),
        .idex_instr (idex_instr),
        .idex_npc   (idex_npc),
        .idex_rdat1 (idex_rdat1),
        .idex_rdat2 (idex_rdat2),
        .idex_imm   (idex_imm),
        .idex_ctrl  (idex_ctrl),
        .halted     (halted),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]       instr;
        logic [WORD_W-1:0] npc;
        logic [WORD_W-1:0] rdat1;
        logic [WORD_W-1:0] rdat2;
        logic [WORD_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic idle();
        ifid_valid = 1'b0;
        flush      = 1'b0;
        ex_ready   = 1'b1;
        ex_memread = 1'b0;
        ex_rd      = '0;
        wb_wen     = 1'b0;
        wb_jal     = 1'b0;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] npc);
        ifid_valid = 1'b1;
        ifid_instr = instr;
        ifid_npc   = npc;
    endtask

    task automatic expect_issue(input logic [31:0] instr, input logic [31:0] npc,
                                input logic [31:0] rdat1, input logic [31:0] rdat2,
                                input logic [31:0] imm, input logic [15:0] ctrl);
        exp_t e;
        e.instr = instr;
        e.npc   = npc;
        e.rdat1 = rdat1;
        e.rdat2 = rdat2;
        e.imm   = imm;
        e.ctrl  = ctrl;
        sb_q.push_back(e);
    endtask

    task automatic cmp_fields(input string tag);
        check({tag, "_instr"}, idex_instr, last_exp.instr);
        check({tag, "_npc"},   idex_npc,   last_exp.npc);
        check({tag, "_rdat1"}, idex_rdat1, last_exp.rdat1);
        check({tag, "_rdat2"}, idex_rdat2, last_exp.rdat2);
        check({tag, "_imm"},   idex_imm,   last_exp.imm);
        check({tag, "_ctrl"},  idex_ctrl,  last_exp.ctrl);
    endtask

    // A live ID/EX entry after an edge with ex_ready=1 is a new issue; with ex_ready=0 it is a hold
    task automatic sb_check(input logic loaded);
        if (idex_valid === 1'b1) begin
            if (loaded) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_issue", idex_valid, 1'b0);
                end else begin
                    last_exp = sb_q.pop_front();
                    cmp_fields("issue");
                end
            end else begin
                cmp_fields("hold");
            end
        end
    endtask

    task automatic tick();
        logic ready_at_edge;
        ready_at_edge = ex_ready;
        @(posedge CLK);
        #1;
        sb_check(ready_at_edge);
    endtask

    task automatic wb_write(input logic [4:0] sel, input logic [31:0] data);
        wb_wen  = 1'b1;
        wb_wsel = sel;
        wb_wdat = data;
        wb_jal  = 1'b0;
        tick();
        wb_wen  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  idex_valid, 1'b0);
        check({tag, "_instr"},  idex_instr, 32'h0);
        check({tag, "_npc"},    idex_npc,   32'h0);
        check({tag, "_rdat1"},  idex_rdat1, 32'h0);
        check({tag, "_rdat2"},  idex_rdat2, 32'h0);
        check({tag, "_imm"},    idex_imm,   32'h0);
        check({tag, "_ctrl"},   idex_ctrl,  16'h0);
        check({tag, "_halted"}, halted,     1'b0);
        check({tag, "_stall"},  stall_cnt,  16'h0);
    endtask

    logic [5:0]  ext_op   [4] = '{6'h0D, 6'h08, 6'h0F, 6'h0B};
    logic [31:0] ext_imm  [4] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'h0000_8001};
    logic [15:0] ext_ctrl [4] = '{16'h0048, 16'h0049, 16'h004A, 16'h004B};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] instr;
        logic [31:0] halt_instr;
        logic [15:0] exp_stall;

        halt_instr = {6'h3F, 26'h0};
        exp_stall  = 16'h0;

        // Reset state
        nRST = 1'b0;
        idle();
        ifid_instr = '0;
        ifid_npc   = '0;
        wb_wsel    = '0;
        wb_wdat    = '0;
        wb_npc     = '0;
        tick();
        tick();
        check_all_zero("rst");
        #1 check("rst_ready", ifid_ready, 1'b1);
        nRST = 1'b1;

        // Preload registers; r0 write must be ignored, r5 gets the jal npc
        wb_write(5'd1, 32'h1111_1111);
        wb_write(5'd2, 32'h2222_2222);
        wb_write(5'd8, 32'h8888_8888);
        wb_write(5'd0, 32'hFFFF_FFFF);
        wb_jal  = 1'b1;
        wb_npc  = 32'h0040_0010;
        wb_wdat = 32'hDEAD_BEEF;
        wb_wsel = 5'd5;
        wb_wen  = 1'b1;
        tick();
        wb_wen  = 1'b0;
        wb_jal  = 1'b0;

        // Immediate extension, all four modes with imm 0x8001
        for (int m = 0; m < 4; m++) begin
            instr = i_type(ext_op[m], 5'd1, 5'd2, 16'h8001);
            present(instr, 32'h100 + 32'(m * 4));
            expect_issue(instr, 32'h100 + 32'(m * 4), 32'h1111_1111, 32'h2222_2222, ext_imm[m], ext_ctrl[m]);
            #1 check($sformatf("ext%0d_ready", m), ifid_ready, 1'b1);
            tick();
            check($sformatf("ext%0d_valid", m), idex_valid, 1'b1);
        end

        // jal-written r5 and r0 (written with all-ones earlier) read back
        instr = r_type(5'd5, 5'd0, 5'd6, 6'h20);
        present(instr, 32'h120);
        expect_issue(instr, 32'h120, 32'h0040_0010, 32'h0, {16'h0, instr[15:0]}, 16'h8088);
        tick();
        check("jal_valid", idex_valid, 1'b1);

        // WB to r0 while ID reads r0: no collision, r0 still reads 0
        wb_wen  = 1'b1;
        wb_wsel = 5'd0;
        wb_wdat = 32'hFFFF_FFFF;
        instr = r_type(5'd0, 5'd0, 5'd7, 6'h20);
        present(instr, 32'h124);
        expect_issue(instr, 32'h124, 32'h0, 32'h0, {16'h0, instr[15:0]}, 16'h8088);
        #1 check("r0_ready", ifid_ready, 1'b1);
        tick();
        check("r0_valid", idex_valid, 1'b1);
        wb_wen = 1'b0;

        // Load in EX targeting r0 is not a hazard
        ex_memread = 1'b1;
        ex_rd      = 5'd0;
        instr = r_type(5'd0, 5'd1, 5'd12, 6'h20);
        present(instr, 32'h128);
        expect_issue(instr, 32'h128, 32'h0, 32'h1111_1111, {16'h0, instr[15:0]}, 16'h8088);
        #1 check("lu_r0_ready", ifid_ready, 1'b1);
        tick();
        check("lu_r0_valid", idex_valid, 1'b1);

        // Load-use: lw r8 in EX, add r9,r8,r8 in ID -> one bubble then issue
        ex_rd = 5'd8;
        instr = r_type(5'd8, 5'd8, 5'd9, 6'h20);
        present(instr, 32'h200);
        #1 check("lu_ready", ifid_ready, 1'b0);
        tick();
        exp_stall++;
        check("lu_bubble_valid", idex_valid, 1'b0);
        check("lu_bubble_instr_hold", idex_instr, last_exp.instr);
        check("lu_stall_cnt", stall_cnt, exp_stall);
        ex_memread = 1'b0;
        expect_issue(instr, 32'h200, 32'h8888_8888, 32'h8888_8888, {16'h0, instr[15:0]}, 16'h8088);
        #1 check("lu_release_ready", ifid_ready, 1'b1);
        tick();
        check("lu_issue_valid", idex_valid, 1'b1);
        check("lu_issue_stall_cnt", stall_cnt, exp_stall);

        // WB writes r3=0x1234 while ID reads r3
        wb_wen  = 1'b1;
        wb_wsel = 5'd3;
        wb_wdat = 32'h0000_1234;
        instr = r_type(5'd3, 5'd1, 5'd10, 6'h20);
        present(instr, 32'h204);
`ifdef STAGE_ID_BYPASS_EN
        expect_issue(instr, 32'h204, 32'h0000_1234, 32'h1111_1111, {16'h0, instr[15:0]}, 16'h8088);
        #1 check("coll_ready", ifid_ready, 1'b1);
        tick();
        check("coll_valid", idex_valid, 1'b1);
        check("coll_stall_cnt", stall_cnt, exp_stall);
        wb_wen = 1'b0;
`else
        #1 check("coll_ready", ifid_ready, 1'b0);
        tick();
        exp_stall++;
        check("coll_bubble_valid", idex_valid, 1'b0);
        check("coll_stall_cnt", stall_cnt, exp_stall);
        wb_wen = 1'b0;
        expect_issue(instr, 32'h204, 32'h0000_1234, 32'h1111_1111, {16'h0, instr[15:0]}, 16'h8088);
        #1 check("coll_release_ready", ifid_ready, 1'b1);
        tick();
        check("coll_issue_valid", idex_valid, 1'b1);
`endif

        // EX backpressure: ID/EX holds, stall counted
        ex_ready = 1'b0;
        instr = r_type(5'd1, 5'd2, 5'd13, 6'h20);
        present(instr, 32'h208);
        #1 check("bp_ready", ifid_ready, 1'b0);
        tick();
        exp_stall++;
        check("bp_hold_valid", idex_valid, 1'b1);
        check("bp_stall_cnt", stall_cnt, exp_stall);
        ex_ready = 1'b1;
        expect_issue(instr, 32'h208, 32'h1111_1111, 32'h2222_2222, {16'h0, instr[15:0]}, 16'h8088);
        tick();
        check("bp_issue_valid", idex_valid, 1'b1);

        // Flush together with load-use: squash, ready high, count unchanged
        flush      = 1'b1;
        ex_memread = 1'b1;
        ex_rd      = 5'd8;
        present(r_type(5'd8, 5'd8, 5'd9, 6'h20), 32'h20C);
        #1 check("fl_lu_ready", ifid_ready, 1'b1);
        tick();
        check("fl_lu_valid", idex_valid, 1'b0);
        check("fl_lu_stall_cnt", stall_cnt, exp_stall);

        // Flush together with a halt: halt is discarded
        ex_memread = 1'b0;
        present(halt_instr, 32'h210);
        tick();
        check("fl_halt_halted", halted, 1'b0);
        check("fl_halt_valid", idex_valid, 1'b0);
        flush = 1'b0;

        // Halt issues once, then the stage refuses everything
        present(halt_instr, 32'h300);
        expect_issue(halt_instr, 32'h300, 32'h0, 32'h0, 32'h0, 16'h0004);
        #1 check("halt_ready", ifid_ready, 1'b1);
        tick();
        check("halt_issue_valid", idex_valid, 1'b1);
        present(r_type(5'd1, 5'd2, 5'd14, 6'h20), 32'h304);
        #1 check("halted_ready", ifid_ready, 1'b0);
        check("halted_flag", halted, 1'b1);
        tick();
        check("halted_valid", idex_valid, 1'b0);
        check("halted_flag2", halted, 1'b1);
        check("halted_stall_cnt", stall_cnt, exp_stall);
        flush = 1'b1;
        tick();
        check("halted_flush_flag", halted, 1'b1);
        check("halted_flush_ready", ifid_ready, 1'b0);
        flush = 1'b0;

        // Asynchronous reset pulse from HALTED clears everything, including the register file
        nRST = 1'b0;
        #1;
        check_all_zero("rst2");
        check("rst2_ready", ifid_ready, 1'b1);
        #2 nRST = 1'b1;
        instr = r_type(5'd1, 5'd2, 5'd14, 6'h20);
        present(instr, 32'h304);
        expect_issue(instr, 32'h304, 32'h0, 32'h0, {16'h0, instr[15:0]}, 16'h8088);
        tick();
        check("post_rst_valid", idex_valid, 1'b1);
        check("post_rst_halted", halted, 1'b0);

        // Stall counter saturates at 0xFFFF
        ex_ready = 1'b0;
        present(r_type(5'd1, 5'd2, 5'd15, 6'h20), 32'h308);
        repeat (65540) @(posedge CLK);
        #1 check("sat_stall_cnt", stall_cnt, 16'hFFFF);
        tick();
        check("sat_stall_cnt_hold", stall_cnt, 16'hFFFF);
        idle();
        tick();
        check("final_valid", idex_valid, 1'b0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
